// File: rtl/chunk_ray_walker_if.sv
// chunk_ray_walker_if: block-lookup port between the ray walker (master) and chunk (slave).
interface chunk_ray_walker_if #(
  parameter int CW = 8,
  parameter int BW = 8
);
  logic [2:0][CW-1:0] chunk_addr_out;
  logic               chunk_read_enable_out;
  logic [BW-1:0]      chunk_block_in;
  logic               chunk_valid_in;
  modport master (output chunk_addr_out, chunk_read_enable_out, input chunk_block_in, chunk_valid_in);
  modport slave (input chunk_addr_out, chunk_read_enable_out, output chunk_block_in, chunk_valid_in);
endinterface

// File: rtl/chunk_ray_walker.sv
// chunk_ray_walker: 3D-DDA voxel walker issuing one chunk lookup per voxel until hit, boundary or step budget.
module chunk_ray_walker #(
  parameter int MAX_STEPS = 128,
  parameter int T_WIDTH = 24,
  parameter int CW = 8,
  parameter int BW = 8,
  parameter int CHUNK_WIDTH = 8,
  parameter logic [BW-1:0] BLOCK_AIR = '0,
  localparam int SW = $clog2(MAX_STEPS + 1)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      start_in,
  input  logic [2:0][CW-1:0]        origin_in,
  input  logic [2:0]                dir_neg_in,
  input  logic [2:0][T_WIDTH-1:0]   t_max_in,
  input  logic [2:0][T_WIDTH-1:0]   t_delta_in,
  output logic                      busy_out,
  output logic                      done_out,
  output logic                      hit_out,
  output logic [2:0][CW-1:0]        hit_pos_out,
  output logic [BW-1:0]             hit_block_out,
  output logic [1:0]                hit_face_out,
  output logic [SW-1:0]             steps_out,
  chunk_ray_walker_if.master        chunk
);
  typedef enum logic [1:0] {IDLE, FETCH, STEP, DONE} state_t;
  localparam logic signed [CW-1:0] LO = CW'(-CHUNK_WIDTH);
  localparam logic signed [CW-1:0] HI = CW'(CHUNK_WIDTH - 1);
  state_t                    r_state;
  logic [2:0][CW-1:0]        r_pos;
  logic [2:0]                r_dir;
  logic [2:0][T_WIDTH-1:0]   r_tmax;
  logic [2:0][T_WIDTH-1:0]   r_tdelta;
  logic [SW-1:0]             r_steps;
  logic [1:0]                r_face;
  logic [1:0]                w_axis;
  logic [2:0][CW-1:0]        w_npos;
  logic [T_WIDTH:0]          w_tsum;
  logic [T_WIDTH-1:0]        w_tnew;
  logic                      w_oob;
  logic [SW-1:0]             w_steps1;
  logic                      w_solid;
  // Ties resolve x over y over z through the <= ordering.
  always_comb begin
    w_axis = (r_tmax[0] <= r_tmax[1] && r_tmax[0] <= r_tmax[2]) ? 2'd0 : (r_tmax[1] <= r_tmax[2]) ? 2'd1 : 2'd2;
    w_npos = r_pos;
    w_npos[w_axis] = r_dir[w_axis] ? r_pos[w_axis] - CW'(1) : r_pos[w_axis] + CW'(1);
    w_tsum = {1'b0, r_tmax[w_axis]} + {1'b0, r_tdelta[w_axis]};
    w_tnew = w_tsum[T_WIDTH] ? '1 : w_tsum[T_WIDTH-1:0];
    w_oob = 1'b0;
    for (int k = 0; k < 3; k++) w_oob = w_oob | ($signed(w_npos[k]) < LO) | ($signed(w_npos[k]) > HI);
    w_steps1 = r_steps + SW'(1);
    w_solid = chunk.chunk_block_in != BLOCK_AIR;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state <= IDLE;
      r_pos <= '0;
      r_dir <= '0;
      r_tmax <= '0;
      r_tdelta <= '0;
      r_steps <= '0;
      r_face <= '0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
      hit_out <= 1'b0;
      hit_pos_out <= '0;
      hit_block_out <= '0;
      hit_face_out <= '0;
      steps_out <= '0;
      chunk.chunk_addr_out <= '0;
      chunk.chunk_read_enable_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (r_state)
        IDLE: if (start_in) begin
          r_state <= FETCH;
          r_pos <= origin_in;
          r_dir <= dir_neg_in;
          r_tmax <= t_max_in;
          r_tdelta <= t_delta_in;
          r_steps <= '0;
          r_face <= '0;
          busy_out <= 1'b1;
          hit_out <= 1'b0;
          hit_pos_out <= '0;
          hit_block_out <= '0;
          hit_face_out <= '0;
          steps_out <= '0;
          chunk.chunk_addr_out <= origin_in;
          chunk.chunk_read_enable_out <= 1'b1;
        end
        FETCH: if (chunk.chunk_valid_in) begin
          r_steps <= w_steps1;
          chunk.chunk_read_enable_out <= 1'b0;
          if (w_solid || w_steps1 == SW'(MAX_STEPS)) begin
            r_state <= DONE;
            busy_out <= 1'b0;
            done_out <= 1'b1;
            hit_out <= w_solid;
            hit_pos_out <= r_pos;
            hit_block_out <= chunk.chunk_block_in;
            hit_face_out <= r_face;
            steps_out <= w_steps1;
          end else r_state <= STEP;
        end
        STEP: begin
          r_pos <= w_npos;
          r_tmax[w_axis] <= w_tnew;
          r_face <= w_axis + 2'd1;
          if (w_oob) begin
            r_state <= DONE;
            busy_out <= 1'b0;
            done_out <= 1'b1;
            hit_out <= 1'b0;
            hit_pos_out <= w_npos;
            hit_block_out <= BLOCK_AIR;
            hit_face_out <= w_axis + 2'd1;
            steps_out <= r_steps;
          end else begin
            r_state <= FETCH;
            chunk.chunk_addr_out <= w_npos;
            chunk.chunk_read_enable_out <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chunk_ray_walker.sv
// tb_chunk_ray_walker: randomized and directed checks of the ray walker against a voxel-walk reference model.
module tb_chunk_ray_walker;
  localparam int CW = 8;
  localparam int BW = 8;
  localparam int CH = 8;
  localparam longint TSAT = (longint'(1) << 24) - 1;
  typedef logic [2:0][CW-1:0] pos_t;
  typedef logic [2:0][23:0] t3_t;
  typedef struct packed {
    logic hit;
    pos_t pos;
    logic [BW-1:0] blk;
    logic [1:0] face;
    logic [7:0] steps;
  } res_t;
  logic clk = 0, rst_n = 0, start = 0, start4 = 0;
  pos_t origin = '0;
  logic [2:0] dir = '0;
  t3_t tmax = '0, tdelta = '0;
  logic busy, done, hit, busy4, done4, hit4;
  pos_t hpos, hpos4;
  logic [7:0] hblk, hblk4, steps;
  logic [1:0] hface, hface4;
  logic [2:0] steps4;
  int total = 0, bad = 0, done_cnt = 0, hold_err = 0, cnt = 0, cnt4 = 0;
  logic [7:0] world [4096];
  pos_t exp_q[$], act_q[$];
  logic prev_re = 0;
  pos_t prev_addr = '0;
  always #5 clk = ~clk;
  chunk_ray_walker_if #(.CW(CW), .BW(BW)) cif ();
  chunk_ray_walker_if #(.CW(CW), .BW(BW)) cif4 ();
  chunk_ray_walker dut (.clk_in(clk), .rst_in(rst_n), .start_in(start), .origin_in(origin), .dir_neg_in(dir),
    .t_max_in(tmax), .t_delta_in(tdelta), .busy_out(busy), .done_out(done), .hit_out(hit), .hit_pos_out(hpos),
    .hit_block_out(hblk), .hit_face_out(hface), .steps_out(steps), .chunk(cif.master));
  chunk_ray_walker #(.MAX_STEPS(4)) dut4 (.clk_in(clk), .rst_in(rst_n), .start_in(start4), .origin_in(origin),
    .dir_neg_in(dir), .t_max_in(tmax), .t_delta_in(tdelta), .busy_out(busy4), .done_out(done4), .hit_out(hit4),
    .hit_pos_out(hpos4), .hit_block_out(hblk4), .hit_face_out(hface4), .steps_out(steps4), .chunk(cif4.master));
  function automatic bit oob(pos_t p);
    for (int k = 0; k < 3; k++) if (int'($signed(p[k])) < -CH || int'($signed(p[k])) >= CH) return 1;
    return 0;
  endfunction
  function automatic logic [7:0] lookup(pos_t p);
    if (oob(p)) return 8'h00;
    return world[(int'($signed(p[0])) + CH) + 16 * (int'($signed(p[1])) + CH) + 256 * (int'($signed(p[2])) + CH)];
  endfunction
  // Behavioural chunk: valid two cycles after the address appears, all air out of bounds.
  always @(posedge clk) begin
    if (!rst_n || !cif.chunk_read_enable_out || cif.chunk_valid_in) begin
      cnt <= 0;
      cif.chunk_valid_in <= 1'b0;
      cif.chunk_block_in <= '0;
    end else if (cnt == 1) begin
      cif.chunk_valid_in <= 1'b1;
      cif.chunk_block_in <= lookup(cif.chunk_addr_out);
    end else cnt <= cnt + 1;
  end
  always @(posedge clk) begin
    if (!rst_n || !cif4.chunk_read_enable_out || cif4.chunk_valid_in) begin
      cnt4 <= 0;
      cif4.chunk_valid_in <= 1'b0;
      cif4.chunk_block_in <= '0;
    end else if (cnt4 == 1) begin
      cif4.chunk_valid_in <= 1'b1;
      cif4.chunk_block_in <= lookup(cif4.chunk_addr_out);
    end else cnt4 <= cnt4 + 1;
  end
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (cif.chunk_read_enable_out && prev_re && cif.chunk_addr_out !== prev_addr) hold_err <= hold_err + 1;
    if (cif.chunk_read_enable_out && !prev_re) act_q.push_back(cif.chunk_addr_out);
    prev_re <= cif.chunk_read_enable_out;
    prev_addr <= cif.chunk_addr_out;
  end
  function automatic res_t ref_walk(pos_t o, logic [2:0] d, t3_t tm, t3_t td, int maxs);
    int p[3];
    longint t[3];
    int a;
    pos_t cur;
    res_t r;
    r = '0;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      p[k] = int'($signed(o[k]));
      t[k] = longint'(tm[k]);
    end
    for (int n = 0; n < 4096; n++) begin
      for (int k = 0; k < 3; k++) cur[k] = CW'(p[k]);
      exp_q.push_back(cur);
      r.steps = r.steps + 8'd1;
      r.pos = cur;
      if (lookup(cur) != 0) begin
        r.hit = 1'b1;
        r.blk = lookup(cur);
        return r;
      end
      if (int'(r.steps) == maxs) return r;
      a = 0;
      if (t[1] < t[a]) a = 1;
      if (t[2] < t[a]) a = 2;
      p[a] = p[a] + (d[a] ? -1 : 1);
      t[a] = (t[a] + longint'(td[a]) > TSAT) ? TSAT : t[a] + longint'(td[a]);
      r.face = 2'(a + 1);
      if (p[a] < -CH || p[a] >= CH) begin
        for (int k = 0; k < 3; k++) r.pos[k] = CW'(p[k]);
        return r;
      end
    end
    return r;
  endfunction
  task automatic clear_world();
    for (int i = 0; i < 4096; i++) world[i] = 8'h00;
  endtask
  task automatic put(input int x, input int y, input int z, input logic [7:0] b);
    world[(x + CH) + 16 * (y + CH) + 256 * (z + CH)] = b;
  endtask
  task automatic setup_x(input pos_t o);
    origin = o;
    dir = 3'b000;
    tmax = {24'hFFFFFF, 24'hFFFFFF, 24'h001000};
    tdelta = {24'hFFFFFF, 24'hFFFFFF, 24'h001000};
  endtask
  task automatic run_ray(input bit use4, output res_t r, output bit ok, output bit bz);
    bit bf;
    act_q.delete();
    @(negedge clk);
    if (use4) start4 = 1; else start = 1;
    @(negedge clk);
    start = 0;
    start4 = 0;
    bf = use4 ? busy4 : busy;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (use4 ? done4 : done) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    bz = bf && !(use4 ? busy4 : busy);
    r = use4 ? {hit4, hpos4, hblk4, hface4, {5'b0, steps4}} : {hit, hpos, hblk, hface, steps};
  endtask
  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({busy, done, hit, hpos, hblk, hface, steps, cif.chunk_read_enable_out, cif.chunk_addr_out} !== '0) begin
      bad++;
      $display("FAIL reset_main got=%h required=0", {busy, done, hit, hpos, hblk, hface, steps, cif.chunk_read_enable_out, cif.chunk_addr_out});
    end
    total++;
    if ({busy4, done4, hit4, hpos4, hblk4, hface4, steps4, cif4.chunk_read_enable_out, cif4.chunk_addr_out} !== '0) begin
      bad++;
      $display("FAIL reset_budget got=%h required=0", {busy4, done4, hit4, hpos4, hblk4, hface4, steps4});
    end
    rst_n = 1;
  endtask
  task automatic test_hit_origin();
    res_t r;
    bit ok, bz;
    int d0;
    clear_world();
    put(0, 0, 0, 8'd3);
    setup_x('0);
    d0 = done_cnt;
    run_ray(0, r, ok, bz);
    repeat (6) @(negedge clk);
    total++;
    if (!ok || r !== {1'b1, 24'h0, 8'd3, 2'd0, 8'd1}) begin
      bad++;
      $display("FAIL hit_origin ok=%0d got=%h required=%h", ok, r, {1'b1, 24'h0, 8'd3, 2'd0, 8'd1});
    end
    total++;
    if (done_cnt - d0 !== 1) begin
      bad++;
      $display("FAIL done_pulses got=%0d required=1", done_cnt - d0);
    end
    total++;
    if (!bz) begin
      bad++;
      $display("FAIL busy_window got=0 required=1");
    end
    total++;
    if (r !== {hit, hpos, hblk, hface, steps} || busy !== 1'b0) begin
      bad++;
      $display("FAIL result_hold got=%h busy=%b required=%h busy=0", {hit, hpos, hblk, hface, steps}, busy, r);
    end
  endtask
  task automatic test_straight_x();
    res_t r;
    bit ok, bz;
    clear_world();
    put(4, 0, 0, 8'd5);
    setup_x('0);
    run_ray(0, r, ok, bz);
    total++;
    if (!ok || r !== {1'b1, 24'h000004, 8'd5, 2'd1, 8'd5}) begin
      bad++;
      $display("FAIL straight_x ok=%0d got=%h required=%h", ok, r, {1'b1, 24'h000004, 8'd5, 2'd1, 8'd5});
    end
    total++;
    if (act_q.size() != 5) begin
      bad++;
      $display("FAIL addr_count got=%0d required=5", act_q.size());
    end else
      for (int i = 0; i < 5; i++) begin
        total++;
        if (act_q[i] !== pos_t'(i)) begin
          bad++;
          $display("FAIL addr_seq[%0d] got=%h required=%h", i, act_q[i], pos_t'(i));
        end
      end
    total++;
    if (hold_err !== 0) begin
      bad++;
      $display("FAIL fetch_hold got=%0d changes required=0", hold_err);
    end
  endtask
  task automatic test_tie_saturation();
    res_t r;
    bit ok, bz;
    pos_t want [3];
    want[0] = {8'h00, 8'h00, 8'hFF};
    want[1] = {8'h00, 8'hFF, 8'hFF};
    want[2] = {8'hFF, 8'hFF, 8'hFF};
    clear_world();
    origin = '0;
    dir = 3'b111;
    tmax = {3{24'h001000}};
    tdelta = {3{24'h001000}};
    run_ray(0, r, ok, bz);
    total++;
    if (!ok || r !== {1'b0, 8'hF8, 8'hF8, 8'hF7, 8'd0, 2'd1, 8'd25}) begin
      bad++;
      $display("FAIL tie_boundary ok=%0d got=%h required=%h", ok, r, {1'b0, 8'hF8, 8'hF8, 8'hF7, 8'd0, 2'd1, 8'd25});
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (act_q.size() < 4 || act_q[i + 1] !== want[i]) begin
        bad++;
        $display("FAIL tie_order[%0d] got=%h required=%h", i, (act_q.size() < 4) ? pos_t'('x) : act_q[i + 1], want[i]);
      end
    end
  endtask
  task automatic test_budget();
    res_t r;
    bit ok, bz;
    clear_world();
    setup_x('0);
    run_ray(1, r, ok, bz);
    total++;
    if (!ok || r !== {1'b0, 24'h000003, 8'd0, 2'd1, 8'd4}) begin
      bad++;
      $display("FAIL step_budget ok=%0d got=%h required=%h", ok, r, {1'b0, 24'h000003, 8'd0, 2'd1, 8'd4});
    end
  endtask
  task automatic test_reset_mid();
    res_t r, e;
    bit ok, bz;
    int d0;
    clear_world();
    setup_x('0);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    total++;
    if (cif.chunk_read_enable_out !== 1'b1) begin
      bad++;
      $display("FAIL mid_fetch_re got=%b required=1", cif.chunk_read_enable_out);
    end
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    d0 = done_cnt;
    total++;
    if ({busy, done, hit, hpos, hblk, hface, steps, cif.chunk_read_enable_out, cif.chunk_addr_out} !== '0) begin
      bad++;
      $display("FAIL reset_mid got=%h required=0", {busy, done, hit, hpos, hblk, hface, steps, cif.chunk_read_enable_out, cif.chunk_addr_out});
    end
    repeat (12) @(negedge clk);
    total++;
    if (done_cnt !== d0) begin
      bad++;
      $display("FAIL reset_no_done got=%0d pulses required=0", done_cnt - d0);
    end
    put(2, 0, 0, 8'd9);
    e = ref_walk(origin, dir, tmax, tdelta, 128);
    run_ray(0, r, ok, bz);
    total++;
    if (!ok || r !== e) begin
      bad++;
      $display("FAIL after_reset ok=%0d got=%h required=%h", ok, r, e);
    end
  endtask
  task automatic test_start_busy();
    res_t r, e;
    bit ok, bz;
    clear_world();
    put(5, 0, 0, 8'd7);
    put(0, 0, 5, 8'd1);
    setup_x('0);
    act_q.delete();
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (6) @(negedge clk);
    origin = {8'd5, 8'd0, 8'd0};
    start = 1;
    @(negedge clk);
    start = 0;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (done) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    r = {hit, hpos, hblk, hface, steps};
    total++;
    if (!ok || r !== {1'b1, 24'h000005, 8'd7, 2'd1, 8'd6}) begin
      bad++;
      $display("FAIL start_busy ok=%0d got=%h required=%h", ok, r, {1'b1, 24'h000005, 8'd7, 2'd1, 8'd6});
    end
    repeat (4) @(negedge clk);
    total++;
    if (busy !== 1'b0 || {hit, hpos, hblk, hface, steps} !== r) begin
      bad++;
      $display("FAIL start_busy_idle busy=%b got=%h required=%h", busy, {hit, hpos, hblk, hface, steps}, r);
    end
    setup_x(hpos);
    run_ray(0, r, ok, bz);
    total++;
    if (!ok || r !== {1'b1, 24'h000005, 8'd7, 2'd0, 8'd1}) begin
      bad++;
      $display("FAIL back_to_back ok=%0d got=%h required=%h", ok, r, {1'b1, 24'h000005, 8'd7, 2'd0, 8'd1});
    end
  endtask
  task automatic test_random();
    res_t r, e;
    bit ok, bz;
    for (int i = 0; i < 4096; i++) world[i] = ($urandom_range(0, 99) < 3) ? 8'($urandom_range(1, 255)) : 8'h00;
    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < 3; k++) begin
        origin[k] = CW'($urandom_range(0, 15) - CH);
        tmax[k] = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(24'hFFF000, 24'hFFFFFF)) : 24'($urandom_range(1, 24'h020000));
        tdelta[k] = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF : 24'($urandom_range(1, 24'h020000));
      end
      dir = 3'($urandom);
      e = ref_walk(origin, dir, tmax, tdelta, 128);
      run_ray(0, r, ok, bz);
      total++;
      if (!ok || r !== e) begin
        bad++;
        $display("FAIL random[%0d] ok=%0d got=%h required=%h", n, ok, r, e);
      end
      total++;
      if (act_q != exp_q) begin
        bad++;
        $display("FAIL random_addrs[%0d] got=%0d lookups required=%0d", n, act_q.size(), exp_q.size());
      end
    end
    total++;
    if (hold_err !== 0) begin
      bad++;
      $display("FAIL random_hold got=%0d changes required=0", hold_err);
    end
  endtask
  initial begin
    clear_world();
    repeat (2) @(negedge clk);
    test_reset();
    test_hit_origin();
    test_straight_x();
    test_tie_saturation();
    test_budget();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
